// File: rtl/sr_pkg.sv
// Shared types and defaults for the SR pulse driver and its button channels.
package sr_pkg;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int NUM_CH              = 2;   // channel 0 = set, channel 1 = reset

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    RELEASING = 2'd2
  } ch_state_e;
endpackage

// File: rtl/btn_debounce_ch.sv
// One pushbutton channel: 2-flop synchronizer, stable-cycle debounce counter
// and a press FSM that strobes o_evt once per accepted press.
module btn_debounce_ch
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_evt
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  ch_state_e        r_state;
  ch_state_e        w_state_nxt;
  logic             r_evt;
  logic             w_evt;
  logic             w_sync;
  logic             w_differ;
  logic             w_accept;

  assign w_sync   = r_sync[1];
  assign w_differ = w_sync ^ r_level;
  assign w_accept = w_differ && (r_cnt == CNT_LAST);
  assign o_evt    = r_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_state <= IDLE;
      r_evt   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_state <= w_state_nxt;
      r_evt   <= w_evt;
      // Any agreeing cycle restarts the stability count.
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= w_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // In IDLE the level is 0, so an acceptance there is always a rising one.
  always_comb begin
    w_state_nxt = r_state;
    w_evt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = PRESSED;
          w_evt       = 1'b1;
        end
      end
      PRESSED: begin
        if (w_accept)     w_state_nxt = IDLE;
        else if (!w_sync) w_state_nxt = RELEASING;
      end
      RELEASING: begin
        if (w_sync)        w_state_nxt = PRESSED;
        else if (w_accept) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: rtl/sr_pulse_driver.sv
// Debounces set/reset pushbuttons and issues arbitrated one-cycle S/R pulses
// to a downstream SR latch, tracking the implied latch state on Q/Qn.
module sr_pulse_driver
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_reset,
  output logic S,
  output logic R,
  output logic Q,
  output logic Qn,
  output logic conflict
);
  logic [NUM_CH-1:0] w_btn;
  logic [NUM_CH-1:0] w_evt;
  logic              w_set_only;
  logic              w_rst_only;
  logic              r_S;
  logic              r_R;
  logic              r_Q;
  logic              r_conflict;

  assign w_btn = {btn_reset, btn_set};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .i_btn(w_btn[g]),
      .o_evt(w_evt[g])
    );
  end

  assign w_set_only = w_evt[0] & ~w_evt[1];
  assign w_rst_only = w_evt[1] & ~w_evt[0];

  // Simultaneous presses cancel each other and only flag a conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_S        <= 1'b0;
      r_R        <= 1'b0;
      r_Q        <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_S        <= w_set_only;
      r_R        <= w_rst_only;
      r_conflict <= w_evt[0] & w_evt[1];
      if (w_set_only)      r_Q <= 1'b1;
      else if (w_rst_only) r_Q <= 1'b0;
    end
  end

  assign S        = r_S;
  assign R        = r_R;
  assign Q        = r_Q;
  assign Qn       = ~r_Q;
  assign conflict = r_conflict;
endmodule

// File: tb/tb_sr_pulse_driver.sv
// Scoreboard bench for sr_pulse_driver with DEBOUNCE_CYCLES=4: directed
// scenarios plus random bouncing checked against a windowed debounce model.
module tb_sr_pulse_driver;
  localparam int D    = 4;
  localparam int MAXC = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_set = 1'b0;
  logic btn_reset = 1'b0;
  logic S, R, Q, Qn, conflict;

  always #5 clk = ~clk;

  sr_pulse_driver #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .btn_set(btn_set), .btn_reset(btn_reset),
    .S(S), .R(R), .Q(Q), .Qn(Qn), .conflict(conflict)
  );

  typedef struct {
    int         cyc;
    logic [2:0] kind;  // {conflict, R, S}
    logic       q;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Per-edge model history; index k = state visible after rising edge k.
  bit effv [2][MAXC];
  bit s2   [2][MAXC];
  bit lvl  [2][MAXC];
  bit flp  [2][MAXC];
  bit ev   [2][MAXC];
  bit mq   [MAXC];

  // A level flips once the synchronized input has disagreed with it for the
  // last D cycles, with no earlier flip inside that window.
  function automatic void model(int k, bit r, bit bs, bit br);
    bit raw [2];
    bit ok, so, ro, co;
    exp_t e;
    raw[0] = bs;
    raw[1] = br;
    for (int ch = 0; ch < 2; ch++) begin
      effv[ch][k] = r ? 1'b0 : raw[ch];
      s2[ch][k]   = r ? 1'b0 : effv[ch][k-1];
      flp[ch][k]  = 1'b0;
      lvl[ch][k]  = lvl[ch][k-1];
      if (r) begin
        lvl[ch][k] = 1'b0;
      end else if (k >= D) begin
        ok = 1'b1;
        for (int j = k - D; j < k; j++)
          if (s2[ch][j] == lvl[ch][j]) ok = 1'b0;
        for (int m = k - D + 1; m < k; m++)
          if (flp[ch][m]) ok = 1'b0;
        if (ok) begin
          lvl[ch][k] = ~lvl[ch][k-1];
          flp[ch][k] = 1'b1;
        end
      end
      ev[ch][k] = !r && !lvl[ch][k-1] && lvl[ch][k];
    end
    so = !r && ev[0][k-1] && !ev[1][k-1];
    ro = !r && ev[1][k-1] && !ev[0][k-1];
    co = !r && ev[0][k-1] && ev[1][k-1];
    mq[k] = r ? 1'b0 : so ? 1'b1 : ro ? 1'b0 : mq[k-1];
    if (so || ro || co) begin
      e.cyc  = k;
      e.kind = {co, ro, so};
      e.q    = mq[k];
      sbq.push_back(e);
    end
  endfunction

  task automatic step(input bit r, input bit bs, input bit br);
    rst       = r;
    btn_set   = bs;
    btn_reset = br;
    @(posedge clk);
    #1;
    if (cyc + 1 >= MAXC) begin
      $display("FAIL cycle_budget: cycle %0d reached limit %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    cyc++;
    model(cyc, r, bs, br);
  endtask

  task automatic hold(input int n, input bit r, input bit bs, input bit br);
    for (int i = 0; i < n; i++) step(r, bs, br);
  endtask

  // Monitor: compares Q/Qn every cycle, pops the scoreboard on each pulse.
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1) begin
      n_cmp++;
      if (Q !== mq[cyc]) begin
        n_bad++;
        $display("FAIL q_state @%0d: got %b expected %b", cyc, Q, mq[cyc]);
      end
      n_cmp++;
      if (Qn !== ~Q) begin
        n_bad++;
        $display("FAIL qn_compl @%0d: got Qn=%b expected %b", cyc, Qn, ~Q);
      end
      if (S === 1'b1 && R === 1'b1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL s_r_both @%0d: got S=R=1 expected at most one", cyc);
      end
      if (S !== 1'b0 || R !== 1'b0 || conflict !== 1'b0) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse @%0d: got {c,R,S}=%b expected none",
                   cyc, {conflict, R, S});
        end else begin
          e = sbq.pop_front();
          if (e.cyc != cyc || e.kind !== {conflict, R, S} || e.q !== Q) begin
            n_bad++;
            $display("FAIL pulse @%0d: got {c,R,S}=%b Q=%b expected {c,R,S}=%b Q=%b @%0d",
                     cyc, {conflict, R, S}, Q, e.kind, e.q, e.cyc);
          end
        end
      end else begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          e = sbq.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL missing_pulse @%0d: got none expected {c,R,S}=%b @%0d",
                   cyc, e.kind, e.cyc);
        end
      end
    end
  end

  initial begin
    int hs, hr;
    bit vs, vr;
    // Reset with set held, then the held button becomes a fresh press.
    hold(2, 1'b1, 1'b1, 1'b0);
    hold(12, 1'b0, 1'b1, 1'b0);
    hold(10, 1'b0, 1'b0, 1'b0);
    hold(2, 1'b1, 1'b0, 1'b0);
    // Long hold on set: a single S pulse.
    hold(8, 1'b0, 1'b0, 1'b0);
    hold(50, 1'b0, 1'b1, 1'b0);
    hold(10, 1'b0, 1'b0, 1'b0);
    // Bouncing reset button, then stable.
    for (int i = 0; i < 10; i++) begin
      hold(2, 1'b0, 1'b0, 1'b0);
      hold(2, 1'b0, 1'b0, 1'b1);
    end
    hold(15, 1'b0, 1'b0, 1'b1);
    hold(10, 1'b0, 1'b0, 1'b0);
    // Q=1, then simultaneous presses: conflict only.
    hold(12, 1'b0, 1'b1, 1'b0);
    hold(10, 1'b0, 1'b0, 1'b0);
    hold(12, 1'b0, 1'b1, 1'b1);
    hold(10, 1'b0, 1'b0, 1'b0);
    // Set held while reset is pressed.
    hold(10, 1'b0, 1'b1, 1'b0);
    hold(12, 1'b0, 1'b1, 1'b1);
    hold(10, 1'b0, 1'b1, 1'b0);
    hold(10, 1'b0, 1'b0, 1'b0);
    // Reset mid-debounce with set still held.
    hold(4, 1'b0, 1'b1, 1'b0);
    hold(1, 1'b1, 1'b1, 1'b0);
    hold(12, 1'b0, 1'b1, 1'b0);
    hold(10, 1'b0, 1'b0, 1'b0);
    // Random bouncing with occasional resets.
    vs = 1'b0; vr = 1'b0; hs = 1; hr = 1;
    for (int i = 0; i < 1500; i++) begin
      if (hs == 0) begin vs = ~vs; hs = $urandom_range(1, 12); end
      if (hr == 0) begin vr = ~vr; hr = $urandom_range(1, 12); end
      hs--;
      hr--;
      step($urandom_range(0, 199) == 0, vs, vr);
    end
    hold(20, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_pulse_end: got none expected {c,R,S}=%b @%0d", e.kind, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
